// File: rtl/lc3_decode.sv
// LC3 decode stage: registers the fetched instruction and npc, and decodes execute,
// writeback and memory control words. Supports flush, hold, illegal flag and a capture count.
module lc3_decode #(
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_decode,
  input  logic             flush,
  input  logic [DW-1:0]    Instr_dout,
  input  logic [DW-1:0]    npc_in,
  output logic [DW-1:0]    IR,
  output logic [DW-1:0]    npc_out,
  output logic [5:0]       E_Control,
  output logic [1:0]       W_Control,
  output logic             Mem_Control,
  output logic             dec_valid,
  output logic             illegal,
  output logic [CNT_W-1:0] decode_count
);

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpLea = 4'b1110;

  logic [DW-1:0]    ir_q, ir_d;
  logic [DW-1:0]    npc_q, npc_d;
  logic [5:0]       e_ctrl_q, e_ctrl_d;
  logic [1:0]       w_ctrl_q, w_ctrl_d;
  logic             mem_ctrl_q, mem_ctrl_d;
  logic             valid_q, valid_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Decoded fields for the incoming instruction word
  logic [1:0] alu_ctrl;
  logic [1:0] pcsel1;
  logic       pcsel2;
  logic       op2sel;
  logic [1:0] w_dec;
  logic       mem_dec;
  logic       ill_dec;

  always_comb begin
    alu_ctrl = 2'b00;
    pcsel1   = 2'b00;
    pcsel2   = 1'b0;
    op2sel   = 1'b0;
    w_dec    = 2'b00;
    mem_dec  = 1'b0;
    ill_dec  = 1'b0;
    case (Instr_dout[15:12])
      OpAdd: op2sel = ~Instr_dout[5];
      OpAnd: begin
        alu_ctrl = 2'b01;
        op2sel   = ~Instr_dout[5];
      end
      OpNot: begin
        alu_ctrl = 2'b10;
        op2sel   = 1'b1;
      end
      OpBr, OpSt: begin
        pcsel1 = 2'b01;
        pcsel2 = 1'b1;
      end
      OpJmp: pcsel1 = 2'b11;
      OpLd: begin
        pcsel1 = 2'b01;
        pcsel2 = 1'b1;
        w_dec  = 2'b01;
      end
      OpLdi: begin
        pcsel1  = 2'b01;
        pcsel2  = 1'b1;
        w_dec   = 2'b01;
        mem_dec = 1'b1;
      end
      OpSti: begin
        pcsel1  = 2'b01;
        pcsel2  = 1'b1;
        mem_dec = 1'b1;
      end
      OpLdr: begin
        pcsel1 = 2'b10;
        w_dec  = 2'b01;
      end
      OpStr: pcsel1 = 2'b10;
      OpLea: begin
        pcsel1 = 2'b01;
        pcsel2 = 1'b1;
        w_dec  = 2'b10;
      end
      default: ill_dec = 1'b1;
    endcase
  end

  always_comb begin
    ir_d       = ir_q;
    npc_d      = npc_q;
    e_ctrl_d   = e_ctrl_q;
    w_ctrl_d   = w_ctrl_q;
    mem_ctrl_d = mem_ctrl_q;
    valid_d    = valid_q;
    illegal_d  = illegal_q;
    count_d    = count_q;
    if (flush) begin
      // npc and count deliberately survive a squash
      ir_d       = '0;
      e_ctrl_d   = '0;
      w_ctrl_d   = '0;
      mem_ctrl_d = 1'b0;
      valid_d    = 1'b0;
      illegal_d  = 1'b0;
    end else if (enable_decode) begin
      ir_d       = Instr_dout;
      npc_d      = npc_in;
      e_ctrl_d   = {alu_ctrl, pcsel1, pcsel2, op2sel};
      w_ctrl_d   = w_dec;
      mem_ctrl_d = mem_dec;
      valid_d    = 1'b1;
      illegal_d  = ill_dec;
      count_d    = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ir_q       <= '0;
      npc_q      <= '0;
      e_ctrl_q   <= '0;
      w_ctrl_q   <= '0;
      mem_ctrl_q <= 1'b0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      ir_q       <= ir_d;
      npc_q      <= npc_d;
      e_ctrl_q   <= e_ctrl_d;
      w_ctrl_q   <= w_ctrl_d;
      mem_ctrl_q <= mem_ctrl_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      count_q    <= count_d;
    end
  end

  assign IR           = ir_q;
  assign npc_out      = npc_q;
  assign E_Control    = e_ctrl_q;
  assign W_Control    = w_ctrl_q;
  assign Mem_Control  = mem_ctrl_q;
  assign dec_valid    = valid_q;
  assign illegal      = illegal_q;
  assign decode_count = count_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Directed, table-driven bench for lc3_decode with hand-written reset, hold, flush
// and counter-wrap sequences.
module tb_lc3_decode;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic        flush;
  logic [15:0] Instr_dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        dec_valid;
  logic        illegal;
  logic [15:0] decode_count;

  lc3_decode #(.DW(16), .CNT_W(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable_decode(enable_decode),
    .flush        (flush),
    .Instr_dout   (Instr_dout),
    .npc_in       (npc_in),
    .IR           (IR),
    .npc_out      (npc_out),
    .E_Control    (E_Control),
    .W_Control    (W_Control),
    .Mem_Control  (Mem_Control),
    .dec_valid    (dec_valid),
    .illegal      (illegal),
    .decode_count (decode_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] instr;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        mem;
    logic        ill;
  } vec_t;

  int          n_checks;
  int          n_fail;
  logic [15:0] exp_count;
  logic [15:0] exp_npc;
  vec_t        vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then sample just after the following rising edge
  task automatic cycle(input logic rst, input logic en, input logic fl,
                       input logic [15:0] instr, input logic [15:0] npc);
    @(negedge clock);
    reset         = rst;
    enable_decode = en;
    flush         = fl;
    Instr_dout    = instr;
    npc_in        = npc;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ir, input logic [15:0] npc,
                         input logic [5:0] e, input logic [1:0] w, input logic mem,
                         input logic v, input logic ill, input logic [15:0] cnt);
    chk({tag, ".IR"}, 32'(IR), 32'(ir));
    chk({tag, ".npc"}, 32'(npc_out), 32'(npc));
    chk({tag, ".E"}, 32'(E_Control), 32'(e));
    chk({tag, ".W"}, 32'(W_Control), 32'(w));
    chk({tag, ".Mem"}, 32'(Mem_Control), 32'(mem));
    chk({tag, ".valid"}, 32'(dec_valid), 32'(v));
    chk({tag, ".illegal"}, 32'(illegal), 32'(ill));
    chk({tag, ".count"}, 32'(decode_count), 32'(cnt));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{16'h12A5, 6'b000000, 2'b00, 1'b0, 1'b0};  // ADD imm
    vecs[1]  = '{16'h1642, 6'b000001, 2'b00, 1'b0, 1'b0};  // ADD reg
    vecs[2]  = '{16'h927F, 6'b100001, 2'b00, 1'b0, 1'b0};  // NOT
    vecs[3]  = '{16'h697E, 6'b001000, 2'b01, 1'b0, 1'b0};  // LDR
    vecs[4]  = '{16'hA201, 6'b000110, 2'b01, 1'b1, 1'b0};  // LDI
    vecs[5]  = '{16'hE005, 6'b000110, 2'b10, 1'b0, 1'b0};  // LEA
    vecs[6]  = '{16'h5020, 6'b010000, 2'b00, 1'b0, 1'b0};  // AND imm
    vecs[7]  = '{16'h5042, 6'b010001, 2'b00, 1'b0, 1'b0};  // AND reg
    vecs[8]  = '{16'hC1C0, 6'b001100, 2'b00, 1'b0, 1'b0};  // JMP
    vecs[9]  = '{16'h4801, 6'b000000, 2'b00, 1'b0, 1'b1};  // JSR illegal
    vecs[10] = '{16'h2201, 6'b000110, 2'b01, 1'b0, 1'b0};  // LD
    vecs[11] = '{16'h3201, 6'b000110, 2'b00, 1'b0, 1'b0};  // ST
    vecs[12] = '{16'h8000, 6'b000000, 2'b00, 1'b0, 1'b1};  // RTI illegal
    vecs[13] = '{16'hB201, 6'b000110, 2'b00, 1'b1, 1'b0};  // STI
    vecs[14] = '{16'hD000, 6'b000000, 2'b00, 1'b0, 1'b1};  // reserved
    vecs[15] = '{16'h7000, 6'b001000, 2'b00, 1'b0, 1'b0};  // STR
    vecs[16] = '{16'hF025, 6'b000000, 2'b00, 1'b0, 1'b1};  // TRAP
    vecs[17] = '{16'h0E05, 6'b000110, 2'b00, 1'b0, 1'b0};  // BR
    vecs[18] = '{16'h1E3F, 6'b000000, 2'b00, 1'b0, 1'b0};  // ADD imm
    vecs[19] = '{16'h0000, 6'b000110, 2'b00, 1'b0, 1'b0};  // BR nop

    reset = 1'b0; enable_decode = 1'b0; flush = 1'b0; Instr_dout = '0; npc_in = '0;

    cycle(1'b0, 1'b1, 1'b0, 16'h1234, 16'h5678);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk_all("reset", 16'h0, 16'h0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);

    cycle(1'b1, 1'b1, 1'b0, 16'h12A5, 16'h3001);
    exp_count = 16'd1;
    exp_npc   = 16'h3001;
    chk_all("add_first", 16'h12A5, 16'h3001, 6'b000000, 2'b00, 1'b0, 1'b1, 1'b0, exp_count);

    for (int i = 0; i < 20; i++) begin
      logic [15:0] npc;
      npc = 16'h3002 + 16'(i);
      cycle(1'b1, 1'b1, 1'b0, vecs[i].instr, npc);
      exp_count++;
      exp_npc = npc;
      chk_all($sformatf("vec%0d", i), vecs[i].instr, npc, vecs[i].e, vecs[i].w,
              vecs[i].mem, 1'b1, vecs[i].ill, exp_count);
    end

    cycle(1'b1, 1'b1, 1'b0, 16'h0E05, 16'h4000);
    exp_count++;
    chk_all("br", 16'h0E05, 16'h4000, 6'b000110, 2'b00, 1'b0, 1'b1, 1'b0, exp_count);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'hBEEF);
      chk_all($sformatf("hold%0d", i), 16'h0E05, 16'h4000, 6'b000110, 2'b00, 1'b0, 1'b1,
              1'b0, exp_count);
    end

    cycle(1'b1, 1'b1, 1'b1, 16'h5020, 16'h4001);
    chk_all("flush", 16'h0, 16'h4000, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, exp_count);
    cycle(1'b1, 1'b0, 1'b0, 16'h5020, 16'h4002);
    chk_all("flush_hold", 16'h0, 16'h4000, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, exp_count);

    // LDI then flush: Mem and W must clear too
    cycle(1'b1, 1'b1, 1'b0, 16'hA201, 16'h4003);
    exp_count++;
    cycle(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
    chk_all("flush_ldi", 16'h0, 16'h4003, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, exp_count);

    cycle(1'b1, 1'b1, 1'b0, 16'hF025, 16'h4010);
    exp_count++;
    chk_all("trap", 16'hF025, 16'h4010, 6'h0, 2'b00, 1'b0, 1'b1, 1'b1, exp_count);
    cycle(1'b1, 1'b1, 1'b1, 16'h1642, 16'h4011);
    chk_all("flush_trap", 16'h0, 16'h4010, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, exp_count);

    // Drive the counter to all-ones, then one more capture must wrap to zero
    @(negedge clock);
    reset = 1'b1; enable_decode = 1'b1; flush = 1'b0; Instr_dout = 16'h0000;
    npc_in = 16'h5000;
    while (exp_count != 16'hFFFF) begin
      @(posedge clock);
      exp_count++;
    end
    #1;
    chk("count_max", 32'(decode_count), 32'hFFFF);
    cycle(1'b1, 1'b1, 1'b0, 16'h1642, 16'h5001);
    exp_count++;
    chk_all("wrap", 16'h1642, 16'h5001, 6'b000001, 2'b00, 1'b0, 1'b1, 1'b0, exp_count);
    cycle(1'b1, 1'b1, 1'b0, 16'h927F, 16'h5002);
    exp_count++;
    chk_all("post_wrap", 16'h927F, 16'h5002, 6'b100001, 2'b00, 1'b0, 1'b1, 1'b0, exp_count);

    cycle(1'b0, 1'b1, 1'b0, 16'h1642, 16'h6000);
    chk_all("reset_mid", 16'h0, 16'h0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 16'h697E, 16'h6001);
    chk_all("after_reset", 16'h697E, 16'h6001, 6'b001000, 2'b01, 1'b0, 1'b1, 1'b0, 16'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_decode.md
Name: lc3_decode

Overview:
- Decode stage of the LC3 pipeline, directly downstream of fetch.
- Registers the instruction word returned by instruction memory together with the fetch stage's npc.
- Produces the execute, writeback and memory control words consumed by the execute stage.
- Adds flush on taken branch, hold when not enabled, an illegal-opcode flag and a wrapping count of decoded instructions.

Parameters:
- DW, 16, instruction/address width (LC3 fixed; only 16 is supported).
- CNT_W, 16, width of decode_count.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- enable_decode  input  1  capture Instr_dout/npc_in this cycle.
- flush  input  1  squash the decode register (branch taken).
- Instr_dout  input  16  instruction word from instruction memory.
- npc_in  input  16  pc+1 from fetch.
- IR  output  16  registered instruction.
- npc_out  output  16  registered npc.
- E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control  output  2  writeback select: 00 ALU, 01 memory, 10 PC-relative (LEA).
- Mem_Control  output  1  1 = indirect access (LDI/STI).
- dec_valid  output  1  registered outputs hold a valid decoded instruction.
- illegal  output  1  captured opcode is unsupported.
- decode_count  output  CNT_W  count of instructions captured since reset.

Behaviour:
- Timing
  - All outputs are registers updated on posedge clock; latency is one cycle from enable_decode to the outputs.
  - Priority each edge: reset low > flush > enable_decode > hold.
- Reset (reset==0 at posedge)
  - IR, npc_out, E_Control, W_Control, Mem_Control, dec_valid, illegal and decode_count all become 0.
  - Reset asserted mid-stream discards any pending capture.
- Flush
  - IR, E_Control, W_Control, Mem_Control, dec_valid and illegal become 0; npc_out holds; decode_count unchanged.
  - Flush wins over a simultaneous enable_decode: that instruction is dropped and not counted.
- Enable (enable_decode==1, no flush)
  - IR<=Instr_dout; npc_out<=npc_in; controls are decoded from Instr_dout[15:12].
  - dec_valid<=1 and decode_count<=decode_count+1, wrapping from 2^CNT_W-1 to 0. Illegal opcodes are counted.
- Hold (enable_decode==0, no flush): every output keeps its value, including dec_valid.
- Decode table (op2select is 1 = register operand, 0 = imm5):
  - ADD 0001: alu 00, op2select=~IR[5], W 00.
  - AND 0101: alu 01, op2select=~IR[5], W 00.
  - NOT 1001: alu 10, op2select 1, W 00.
  - BR 0000: pcselect1 01 (offset9), pcselect2 1 (npc), W 00.
  - JMP 1100: pcselect1 11 (zero), pcselect2 0 (base reg), W 00.
  - LD 0010 / LDI 1010: pcselect1 01, pcselect2 1, W 01. LDI also sets Mem 1.
  - ST 0011 / STI 1011: pcselect1 01, pcselect2 1, W 00. STI also sets Mem 1.
  - LDR 0110: pcselect1 10 (offset6), pcselect2 0, W 01.
  - STR 0111: pcselect1 10, pcselect2 0, W 00.
  - LEA 1110: pcselect1 01, pcselect2 1, W 10.
  - Fields not listed for an opcode are 0. Mem_Control is 0 for all opcodes except LDI and STI.
  - Illegal opcodes are JSR 0100, RTI 1000, reserved 1101 and TRAP 1111. For these: illegal=1, E/W/Mem controls all 0, IR still captured, dec_valid=1.
- Arithmetic: decode_count is unsigned modulo 2^CNT_W. No other arithmetic is performed in this block.

Test Plan:
- Reset/ADD sequence:
  - Hold reset=0 for 2 cycles → all outputs 0.
  - Release, enable_decode=1, Instr_dout=16'h12A5 (ADD imm), npc_in=16'h3001 → next edge IR=12A5, npc_out=3001, E_Control=6'b000000, W=00, dec_valid=1, decode_count=1.
- Operand/ALU decode:
  - Instr 16'h1642 (ADD reg) → E_Control=6'b000001.
  - Instr 16'h927F (NOT) → E_Control=6'b100001, W=00.
- Memory ops:
  - Instr 16'h697E (LDR) → E_Control=6'b001000, W=01, Mem=0.
  - Instr 16'hA201 (LDI) → E_Control=6'b000110, W=01, Mem=1.
  - Instr 16'hE005 (LEA) → W=10.
- Hold and flush:
  - Capture 16'h0E05 (BR) → E_Control=6'b000110.
  - Drop enable_decode for 3 cycles → all outputs unchanged.
  - Assert flush with enable_decode=1 and Instr=16'h5020 → IR=0, dec_valid=0, npc_out unchanged, decode_count unchanged.
- Illegal and wrap:
  - Instr 16'hF025 (TRAP) → illegal=1, all controls 0, dec_valid=1.
  - Preload decode_count to 16'hFFFF via 65535 enabled captures (or force), then one more capture → decode_count=0.
- Reset mid-stream: assert reset=0 in the same cycle as enable_decode=1 with 16'h1642 → all outputs 0 next edge, decode_count=0.
